// File: rtl/weight_stream_memory.sv
// Multi-PE weight store: runtime-loadable banks streamed as fold words
// (synapse fold inner, neuron fold outer) over a valid/ready output.
module weight_stream_bank #(
  parameter int    W         = 64,
  parameter int    D         = 18,
  parameter int    DA        = 5,
  parameter string INIT_FILE = "",
  parameter int    IDX       = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [DA-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [DA-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [D];
  logic [W-1:0] rdata_q;

  // Storage is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module weight_stream_memory #(
  parameter int    SIMD          = 32,
  parameter int    WEIGHT_LEVELS = 2,
  parameter int    PE            = 4,
  parameter int    SYN_FOLD      = 18,
  parameter int    NEURON_FOLD   = 1,
  parameter int    ADDR_W        = 12,
  parameter int    PE_W          = 2,
  parameter string INIT_FILE     = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PE_W-1:0]        load_pe,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [SIMD*WEIGHT_LEVELS-1:0] load_data,
  output logic                   load_err,
  input  logic                   start,
  input  logic [15:0]            passes,
  output logic                   busy,
  output logic [PE*SIMD*WEIGHT_LEVELS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done
);
  localparam int W   = SIMD * WEIGHT_LEVELS;
  localparam int D   = SYN_FOLD * NEURON_FOLD;
  localparam int DA  = (D > 1) ? $clog2(D) : 1;
  localparam int SFW = (SYN_FOLD > 1) ? $clog2(SYN_FOLD) : 1;
  localparam int NFW = (NEURON_FOLD > 1) ? $clog2(NEURON_FOLD) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [15:0]    passes_q, passes_d, pass_q, pass_d;
  logic [SFW-1:0] sf_q, sf_d;
  logic [NFW-1:0] nf_q, nf_d;
  logic           rd_done_q, rd_done_d;
  logic           primed_q, primed_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           done_q, load_err_q;

  logic          run, rd, fin, load_ok, sf_wrap, nf_wrap, pass_wrap;
  logic [DA-1:0] rd_addr;

  assign run       = (state_q == S_RUN);
  assign sf_wrap   = (sf_q == SFW'(SYN_FOLD - 1));
  assign nf_wrap   = (nf_q == NFW'(NEURON_FOLD - 1));
  assign pass_wrap = (pass_q == passes_q - 16'd1);
  // primed_q inserts the one idle cycle between entering RUN and the first read.
  assign rd        = run & primed_q & ~rd_done_q & (~out_valid_q | out_ready);
  // Once the final read has issued, the word in the output register is the last one.
  assign fin       = run & rd_done_q & out_valid_q & out_ready;
  assign rd_addr   = DA'(int'(nf_q) * SYN_FOLD + int'(sf_q));
  assign load_ok   = load_en & ~run & ({1'b0, load_pe} < (PE_W+1)'(PE))
                   & (load_addr < ADDR_W'(D));

  always_comb begin
    state_d   = state_q;
    passes_d  = passes_q;
    pass_d    = pass_q;
    sf_d      = sf_q;
    nf_d      = nf_q;
    rd_done_d = rd_done_q;
    if (state_q == S_IDLE && start) begin
      state_d   = S_RUN;
      passes_d  = (passes == 16'd0) ? 16'd1 : passes;
      pass_d    = '0;
      sf_d      = '0;
      nf_d      = '0;
      rd_done_d = 1'b0;
    end
    if (rd) begin
      sf_d = sf_wrap ? '0 : sf_q + 1'b1;
      if (sf_wrap) nf_d = nf_wrap ? '0 : nf_q + 1'b1;
      if (sf_wrap && nf_wrap) begin
        pass_d    = pass_wrap ? '0 : pass_q + 16'd1;
        rd_done_d = pass_wrap;
      end
    end
    if (fin) state_d = S_IDLE;
    out_valid_d = rd ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_last_d  = rd ? (sf_wrap & nf_wrap) : out_last_q;
    primed_d    = run & ~fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      passes_q    <= 16'd1;
      pass_q      <= '0;
      sf_q        <= '0;
      nf_q        <= '0;
      rd_done_q   <= 1'b0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      passes_q    <= passes_d;
      pass_q      <= pass_d;
      sf_q        <= sf_d;
      nf_q        <= nf_d;
      rd_done_q   <= rd_done_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= fin;
      load_err_q  <= load_en & ~load_ok;
    end
  end

  for (genvar g = 0; g < PE; g++) begin : g_bank
    weight_stream_bank #(
      .W(W), .D(D), .DA(DA), .INIT_FILE(INIT_FILE), .IDX(g)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (load_ok && load_pe == PE_W'(g)),
      .waddr_i (load_addr[DA-1:0]),
      .wdata_i (load_data),
      .re_i    (rd),
      .raddr_i (rd_addr),
      .rdata_o (out_data[g*W +: W])
    );
  end

  assign busy      = run;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign load_err  = load_err_q;
endmodule
